// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with a double-buffered output register.
// Optional trailing even-parity bit per frame when DESER_PARITY_EN is defined.
module serial_deserializer #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_in,
  input  logic         s_valid,
  input  logic         s_start,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         overrun,
  output logic         frame_err
`ifdef DESER_PARITY_EN
  ,
  output logic         parity_err
`endif
);

  localparam int CW = $clog2(N + 2);
`ifdef DESER_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   sr, sr_nx, base, shifted, word, m_data_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           m_valid_nx, overrun_nx, frame_err_nx, done;
`ifdef DESER_PARITY_EN
  logic           parity_err_nx;
`endif

  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    cnt_nx       = cnt;
    m_data_nx    = m_data;
    m_valid_nx   = m_valid;
    overrun_nx   = 1'b0;
    frame_err_nx = 1'b0;
    done         = 1'b0;
    word         = shifted;
`ifdef DESER_PARITY_EN
    parity_err_nx = 1'b0;
`endif
    // A start bit always begins from an empty register.
    base    = s_start ? '0 : sr;
    shifted = LSB_FIRST ? {s_in, base[N-1:1]} : {base[N-2:0], s_in};

    if (m_valid && m_ready) m_valid_nx = 1'b0;

    case (state)
      IDLE: begin
        if (s_valid && s_start) begin
          sr_nx    = shifted;
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (s_valid) begin
          if (s_start) begin
            frame_err_nx = 1'b1;
            sr_nx        = shifted;
            cnt_nx       = CW'(1);
          end else if (cnt == CW'(FL - 1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
`ifdef DESER_PARITY_EN
            // Final bit is the parity bit; data bits are already in sr.
            word = sr;
            if (^{sr, s_in}) parity_err_nx = 1'b1;
            else             done          = 1'b1;
`else
            done = 1'b1;
`endif
          end else begin
            sr_nx  = shifted;
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (done) begin
      if (m_valid && !m_ready) begin
        overrun_nx = 1'b1;
      end else begin
        m_data_nx  = word;
        m_valid_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      cnt       <= cnt_nx;
      m_data    <= m_data_nx;
      m_valid   <= m_valid_nx;
      overrun   <= overrun_nx;
      frame_err <= frame_err_nx;
`ifdef DESER_PARITY_EN
      parity_err <= parity_err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: MSB-first and LSB-first instances
// share one stimulus stream; each output is checked against hand-computed values.
module tb_serial_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, s_in, s_valid, s_start, m_ready;
  logic [7:0] md_m, md_l;
  logic       mv_m, mv_l, ov_m, ov_l, fe_m, fe_l;
  logic       mv_before_last;
`ifdef DESER_PARITY_EN
  logic       pe_m, pe_l;
`endif

  int tests = 0;
  int fails = 0;

  serial_deserializer #(.N(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .m_data(md_m), .m_valid(mv_m), .m_ready(m_ready), .overrun(ov_m), .frame_err(fe_m)
`ifdef DESER_PARITY_EN
    , .parity_err(pe_m)
`endif
  );

  serial_deserializer #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .m_data(md_l), .m_valid(mv_l), .m_ready(m_ready), .overrun(ov_l), .frame_err(fe_l)
`ifdef DESER_PARITY_EN
    , .parity_err(pe_l)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st, input logic rdy);
    s_in    = b;
    s_start = st;
    s_valid = 1'b1;
    m_ready = rdy;
    tick();
    s_valid = 1'b0;
    s_start = 1'b0;
    m_ready = 1'b0;
  endtask

  // Sends one MSB-first frame (plus correct even parity when enabled);
  // rdy_last raises m_ready only on the frame's final bit.
  task automatic send_word(input logic [7:0] w, input logic rdy_last, input bit gaps);
    logic last;
    for (int i = 7; i >= 0; i--) begin
`ifdef DESER_PARITY_EN
      last = 1'b0;
`else
      last = (i == 0);
      if (last) mv_before_last = mv_m;
`endif
      send_bit(w[i], i == 7, last & rdy_last);
      if (gaps && i > 0) tick();
    end
`ifdef DESER_PARITY_EN
    mv_before_last = mv_m;
    send_bit(^w, 1'b0, rdy_last);
`endif
  endtask

  task automatic consume();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_in = 1'b1; s_valid = 1'b1; s_start = 1'b1; m_ready = 1'b0;
    tick();
    tick();
    chk("reset_mvalid", mv_m, 1'b0);
    chk("reset_mdata", md_m, 8'h00);
    chk("reset_overrun", ov_m, 1'b0);
    chk("reset_frame_err", fe_m, 1'b0);
`ifdef DESER_PARITY_EN
    chk("reset_parity_err", pe_m, 1'b0);
`endif
    reset = 1'b0; s_valid = 1'b0; s_start = 1'b0;
    tick();
    chk("post_reset_idle", mv_m, 1'b0);

    // Bits without a start marker in IDLE are ignored.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    send_word(8'hA5, 1'b0, 1'b0);
    chk("a5_latency_before", mv_before_last, 1'b0);
    chk("a5_mvalid", mv_m, 1'b1);
    chk("a5_msb_data", md_m, 8'hA5);
    chk("a5_lsb_data", md_l, 8'hA5);
    chk("a5_no_overrun", ov_m, 1'b0);
    consume();
    chk("consume_clears", mv_m, 1'b0);

    send_word(8'h12, 1'b0, 1'b1);
    chk("gap_msb_data", md_m, 8'h12);
    chk("gap_lsb_data", md_l, 8'h48);
    chk("gap_mvalid", mv_l, 1'b1);
    consume();

    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("ovr_pulse_msb", ov_m, 1'b1);
    chk("ovr_pulse_lsb", ov_l, 1'b1);
    chk("ovr_keep_data", md_m, 8'h3C);
    chk("ovr_mvalid", mv_m, 1'b1);
    tick();
    chk("ovr_one_cycle", ov_m, 1'b0);

    send_word(8'h5A, 1'b1, 1'b0);
    chk("rdy_reload_data", md_m, 8'h5A);
    chk("rdy_reload_mvalid", mv_m, 1'b1);
    chk("rdy_reload_no_ovr", ov_m, 1'b0);
    consume();
    chk("rdy_consumed", mv_m, 1'b0);

    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    chk("ferr_pulse", fe_m, 1'b1);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("ferr_one_cycle", fe_m, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1'b0);
`ifdef DESER_PARITY_EN
    send_bit(1'b0, 1'b0, 1'b0);
`endif
    chk("ferr_data", md_m, 8'hFF);
    chk("ferr_mvalid", mv_m, 1'b1);
    consume();

    // Reset mid-frame drops the partial word silently.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_no_ferr", fe_m, 1'b0);
    chk("midrst_mvalid", mv_m, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0, 1'b0);
    chk("midrst_discarded", mv_m, 1'b0);
    send_word(8'h81, 1'b0, 1'b0);
    chk("after_rst_data", md_m, 8'h81);
    chk("after_rst_mvalid", mv_m, 1'b1);
    consume();

`ifdef DESER_PARITY_EN
    send_bit(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    chk("par_err_pulse", pe_m, 1'b1);
    chk("par_err_no_mvalid", mv_m, 1'b0);
    tick();
    chk("par_err_one_cycle", pe_m, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
